// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with demand-driven side-road phase and optional pedestrian walk.
// Define TRAFFIC_PED_EN to compile in the pedestrian request latch and PED_WALK phase.
module traffic_light_ctrl #(
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 20,
  parameter int MIN_GREEN = 5,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s,
  input  logic       ped_req,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic       walk
);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

`ifdef TRAFFIC_PED_EN
  localparam logic PED_EN = 1'b1;
`else
  localparam logic PED_EN = 1'b0;
`endif

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  // A phase of duration D ends on the edge where the timer reads D-1.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pend_q, ped_pend_d;
  logic             entering_walk_s;

  function automatic logic [1:0] lamp_a_f(input state_t st);
    case (st)
      A_GREEN:  return LAMP_GRN;
      A_YELLOW: return LAMP_YEL;
      default:  return LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b_f(input state_t st);
    case (st)
      B_GREEN:  return LAMP_GRN;
      B_YELLOW: return LAMP_YEL;
      default:  return LAMP_RED;
    endcase
  endfunction

  // Next-state, phase timer and pedestrian latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GREEN: begin
        if ((s | ped_pend_q) && (timer_q >= MIN_LAST)) state_d = A_YELLOW;
        else                                          state_d = A_GREEN;
      end
      A_YELLOW: begin
        if (timer_q == YELLOW_LAST) state_d = ALLRED_AB;
        else                        state_d = A_YELLOW;
      end
      ALLRED_AB: begin
        if (timer_q == ALLRED_LAST) state_d = ped_pend_q ? PED_WALK : B_GREEN;
        else                        state_d = ALLRED_AB;
      end
      B_GREEN: begin
        if ((timer_q == GREEN_LAST) || (!s && (timer_q >= MIN_LAST))) state_d = B_YELLOW;
        else                                                           state_d = B_GREEN;
      end
      B_YELLOW: begin
        if (timer_q == YELLOW_LAST) state_d = ALLRED_BA;
        else                        state_d = B_YELLOW;
      end
      ALLRED_BA: begin
        if (timer_q == ALLRED_LAST) state_d = A_GREEN;
        else                        state_d = ALLRED_BA;
      end
      PED_WALK: begin
        if (timer_q == WALK_LAST) state_d = s ? B_GREEN : A_GREEN;
        else                      state_d = PED_WALK;
      end
      default: state_d = ALLRED_BA;
    endcase

    if (state_d != state_q)       timer_d = '0;
    else if (timer_q == TIMER_MAX) timer_d = timer_q;
    else                           timer_d = timer_q + CNT_W'(1);

    entering_walk_s = (state_d == PED_WALK) && (state_q != PED_WALK);
    ped_pend_d      = PED_EN & (ped_req | (ped_pend_q & ~entering_walk_s));
  end

  // State, timer and lamp registers; lamps decode the next state so they move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALLRED_BA;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
      light_a    <= LAMP_RED;
      light_b    <= LAMP_RED;
      walk       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      light_a    <= lamp_a_f(state_d);
      light_b    <= lamp_b_f(state_d);
      walk       <= PED_EN & (state_d == PED_WALK);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized and directed bench for traffic_light_ctrl against a phase/duration reference model.
// Honours TRAFFIC_PED_EN the same way as the design.
module tb_traffic_light_ctrl;

  localparam int CNT_W     = 8;
  localparam int GREEN_T   = 20;
  localparam int MIN_GREEN = 5;
  localparam int YELLOW_T  = 4;
  localparam int ALLRED_T  = 2;
  localparam int WALK_T    = 10;

`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int P_AG = 0, P_AY = 1, P_RAB = 2, P_BG = 3, P_BY = 4, P_RBA = 5, P_WALK = 6;

  localparam logic [4:0] PAT_AG   = 5'b10_00_0;
  localparam logic [4:0] PAT_AY   = 5'b01_00_0;
  localparam logic [4:0] PAT_RED  = 5'b00_00_0;
  localparam logic [4:0] PAT_BG   = 5'b00_10_0;
  localparam logic [4:0] PAT_BY   = 5'b00_01_0;
  localparam logic [4:0] PAT_WALK = 5'b00_00_1;

  logic       clk = 1'b0;
  logic       rst, s, ped_req;
  logic [1:0] light_a, light_b;
  logic       walk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current phase, cycles already spent in it, pending pedestrian request.
  int m_phase = P_RBA;
  int m_spent = 0;
  bit m_pend  = 1'b0;

  int tab_a [7] = '{2, 1, 0, 0, 0, 0, 0};
  int tab_b [7] = '{0, 0, 0, 2, 1, 0, 0};
  int tab_w [7] = '{0, 0, 0, 0, 0, 0, 1};

  traffic_light_ctrl #(
    .CNT_W(CNT_W), .GREEN_T(GREEN_T), .MIN_GREEN(MIN_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .rst(rst), .s(s), .ped_req(ped_req),
    .light_a(light_a), .light_b(light_b), .walk(walk)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] cur_pat();
    return {light_a, light_b, walk};
  endfunction

  // Advance the model by one clock edge using the inputs the DUT saw at that edge.
  task automatic model_edge(input bit si, input bit pi, input bit ri);
    int nxt;
    int lasted;
    if (ri) begin
      m_phase = P_RBA;
      m_spent = 0;
      m_pend  = 1'b0;
    end else begin
      lasted = m_spent + 1;
      nxt    = m_phase;
      case (m_phase)
        P_AG:   if ((si || m_pend) && lasted >= MIN_GREEN) nxt = P_AY;
        P_AY:   if (lasted == YELLOW_T) nxt = P_RAB;
        P_RAB:  if (lasted == ALLRED_T) nxt = m_pend ? P_WALK : P_BG;
        P_BG:   if (lasted == GREEN_T || (!si && lasted >= MIN_GREEN)) nxt = P_BY;
        P_BY:   if (lasted == YELLOW_T) nxt = P_RBA;
        P_RBA:  if (lasted == ALLRED_T) nxt = P_AG;
        P_WALK: if (lasted == WALK_T) nxt = si ? P_BG : P_AG;
        default: nxt = P_RBA;
      endcase
      m_pend  = PED_EN && (pi || (m_pend && !(nxt == P_WALK && m_phase != P_WALK)));
      m_spent = (nxt != m_phase) ? 0 : lasted;
      m_phase = nxt;
    end
  endtask

  task automatic step(input bit si, input bit pi, input bit ri);
    int nonred;
    s       = si;
    ped_req = pi;
    rst     = ri;
    @(posedge clk);
    model_edge(si, pi, ri);
    @(negedge clk);
    check_val("light_a", 32'(light_a), 32'(tab_a[m_phase]));
    check_val("light_b", 32'(light_b), 32'(tab_b[m_phase]));
    check_val("walk", 32'(walk), 32'(tab_w[m_phase]));
    nonred = int'(light_a != 2'b00) + int'(light_b != 2'b00);
    check_val("safety", 32'(nonred <= 1 && !(walk && nonred > 0)), 32'd1);
  endtask

  task automatic run_to(input bit si, input bit pi, input logic [4:0] target, input string tag);
    int k = 0;
    while (cur_pat() != target && k < 200) begin
      step(si, pi, 1'b0);
      k++;
    end
    if (k >= 200) check_val({"reach_", tag}, 32'd0, 32'd1);
  endtask

  // Number of consecutive cycles the current lamp pattern persists, counting the present one.
  task automatic hold_len(input bit si, input bit pi, output int n);
    logic [4:0] p;
    p = cur_pat();
    n = 1;
    step(si, pi, 1'b0);
    while (cur_pat() == p && n < 200) begin
      n++;
      step(si, pi, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    bit rs;
    bit rp;
    bit rr;
    s = 1'b0; ped_req = 1'b0; rst = 1'b1;

    // Reset for three cycles, then two all-red cycles before A green.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check_val("rst_pat", 32'(cur_pat()), 32'(PAT_RED));
    hold_len(1'b0, 1'b0, n);
    check_val("rst_allred_len", 32'(n), 32'(ALLRED_T));
    check_val("rst_then_ag", 32'(cur_pat()), 32'(PAT_AG));

    // No demand: A green holds.
    cnt = 0;
    repeat (100) begin
      step(1'b0, 1'b0, 1'b0);
      if (cur_pat() == PAT_AG) cnt++;
    end
    check_val("ag_hold100", 32'(cnt), 32'd100);

    // Side-road demand from the first A green cycle: full cycle timing.
    step(1'b0, 1'b0, 1'b1);
    run_to(1'b0, 1'b0, PAT_AG, "ag_fresh");
    hold_len(1'b1, 1'b0, n); check_val("ag_len", 32'(n), 32'(MIN_GREEN));
    check_val("ay_pat", 32'(cur_pat()), 32'(PAT_AY));
    hold_len(1'b1, 1'b0, n); check_val("ay_len", 32'(n), 32'(YELLOW_T));
    hold_len(1'b1, 1'b0, n); check_val("rab_len", 32'(n), 32'(ALLRED_T));
    check_val("bg_pat", 32'(cur_pat()), 32'(PAT_BG));
    hold_len(1'b1, 1'b0, n); check_val("bg_max_len", 32'(n), 32'(GREEN_T));
    check_val("by_pat", 32'(cur_pat()), 32'(PAT_BY));
    hold_len(1'b1, 1'b0, n); check_val("by_len", 32'(n), 32'(YELLOW_T));

    // s drops at B timer 7: yellow on the next edge.
    run_to(1'b1, 1'b0, PAT_BG, "bg_a");
    repeat (7) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_val("bg_drop7", 32'(light_b), 32'd1);

    // s drops at B timer 2: B green still lasts the minimum.
    run_to(1'b1, 1'b0, PAT_BG, "bg_b");
    repeat (2) step(1'b1, 1'b0, 1'b0);
    hold_len(1'b0, 1'b0, n);
    check_val("bg_min_len", 32'(n + 2), 32'(MIN_GREEN));

    // One-cycle pedestrian request during A green with no side traffic.
    step(1'b0, 1'b0, 1'b1);
    run_to(1'b0, 1'b0, PAT_AG, "ag_ped");
    repeat (6) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
`ifdef TRAFFIC_PED_EN
    run_to(1'b0, 1'b0, PAT_WALK, "walk");
    hold_len(1'b0, 1'b0, n);
    check_val("walk_len", 32'(n), 32'(WALK_T));
    check_val("after_walk", 32'(cur_pat()), 32'(PAT_AG));
    cnt = 0;
    repeat (20) begin
      step(1'b0, 1'b0, 1'b0);
      if (cur_pat() == PAT_AG) cnt++;
    end
    check_val("ped_cleared", 32'(cnt), 32'd20);
`else
    cnt = 0;
    repeat (30) begin
      step(1'b0, 1'b0, 1'b0);
      if (cur_pat() == PAT_AG) cnt++;
    end
    check_val("ped_ignored", 32'(cnt), 32'd30);
`endif

    // Reset in the middle of B green.
    run_to(1'b1, 1'b0, PAT_BG, "bg_c");
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_val("rst_mid", 32'(cur_pat()), 32'(PAT_RED));
    hold_len(1'b1, 1'b0, n);
    check_val("rst_mid_allred", 32'(n), 32'(ALLRED_T));
    check_val("rst_mid_ag", 32'(cur_pat()), 32'(PAT_AG));

    // Random traffic: slowly varying s, sparse pedestrian requests and resets.
    rs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) rs = ~rs;
      rp = ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rs, rp, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: phase timer width in bits.
REQ-002 SHALL have parameter GREEN_T, default 20: maximum side-road green duration, in cycles.
REQ-003 SHALL have parameter MIN_GREEN, default 5: minimum green duration on either road, in cycles.
REQ-004 SHALL have parameter YELLOW_T, default 4: yellow duration, in cycles.
REQ-005 SHALL have parameter ALLRED_T, default 2: all-red clearance duration, in cycles.
REQ-006 SHALL have parameter WALK_T, default 10: pedestrian walk duration, in cycles.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port s, input, 1 bit: vehicle waiting on side road B.
REQ-010 SHALL have port ped_req, input, 1 bit: pedestrian crossing request.
REQ-011 SHALL have port light_a, output, 2 bits: main road A lamp; 00 red, 01 yellow, 10 green.
REQ-012 SHALL have port light_b, output, 2 bits: side road B lamp, same encoding as light_a.
REQ-013 SHALL have port walk, output, 1 bit: pedestrian walk lamp.

Function
REQ-014 SHALL implement states A_GREEN, A_YELLOW, ALLRED_AB, B_GREEN, B_YELLOW, ALLRED_BA and PED_WALK.
REQ-015 SHALL drive light_a, light_b and walk as registered Moore outputs that change on the same edge as the state.
REQ-016 SHALL drive light_a=10 only in A_GREEN and light_a=01 only in A_YELLOW, with light_a=00 in all other states.
REQ-017 SHALL drive light_b=10 only in B_GREEN and light_b=01 only in B_YELLOW, with light_b=00 in all other states.
REQ-018 SHALL drive walk=1 only in PED_WALK.
REQ-019 SHALL zero the timer on every state change and otherwise increment it, saturating at 2^CNT_W-1.
REQ-020 SHALL make a timed state of duration D last exactly D cycles, exiting on the edge where timer==D-1.
REQ-021 SHALL keep A_GREEN indefinitely while s==0 and no pedestrian request is pending.
REQ-022 SHALL move A_GREEN to A_YELLOW when (s or ped_pend) is 1 and timer>=MIN_GREEN-1.
REQ-023 SHALL move B_GREEN to B_YELLOW when timer==GREEN_T-1, or earlier when s==0 and timer>=MIN_GREEN-1.
REQ-024 SHALL move A_YELLOW to ALLRED_AB, and B_YELLOW to ALLRED_BA, after YELLOW_T cycles.
REQ-025 SHALL move ALLRED_AB after ALLRED_T cycles to PED_WALK if ped_pend is set, otherwise to B_GREEN.
REQ-026 SHALL move ALLRED_BA to A_GREEN after ALLRED_T cycles.
REQ-027 SHALL move PED_WALK after WALK_T cycles to B_GREEN if s==1, otherwise to A_GREEN.
REQ-028 SHALL update ped_pend each edge as ped_req | (ped_pend & ~entering_PED_WALK).
REQ-029 SHALL therefore keep a ped_req arriving on the PED_WALK entry edge or during PED_WALK pending for the next cycle.
REQ-030 SHALL never drive any combination other than at most one road non-red, and never drive walk=1 while either road is non-red.
REQ-031 SHALL treat a parameter that is 0 or exceeds 2^CNT_W-1 as illegal, with undefined behaviour (no check required).

Reset
REQ-032 SHALL, while rst==1 at a rising edge, load state ALLRED_BA, timer 0 and ped_pend 0, and drive light_a=00, light_b=00, walk=0.
REQ-033 SHALL give reset priority over all other inputs, including mid-phase, so that outputs go all red on the next edge.
REQ-034 SHALL, after reset release, hold all red for ALLRED_T cycles and then enter A_GREEN.

Configuration
REQ-035 SHALL use macro TRAFFIC_PED_EN to compile the pedestrian feature in or out.
REQ-036 SHALL, when TRAFFIC_PED_EN is defined, implement ped_pend and PED_WALK as specified above.
REQ-037 SHALL, when TRAFFIC_PED_EN is undefined, keep the ped_req and walk ports, ignore ped_req, tie walk to 0 and treat ped_pend as constant 0.
REQ-038 SHALL, when TRAFFIC_PED_EN is undefined, make PED_WALK unreachable.

Verification (default parameters)
REQ-039 SHALL cover: rst=1 for 3 cycles -> light_a=light_b=00 and walk=0; after release 2 all-red cycles, then light_a=10.
REQ-040 SHALL cover: s=0 and ped_req=0 for 100 cycles after reaching A_GREEN -> light_a remains 10 and light_b remains 00 throughout.
REQ-041 SHALL cover: s=1 from A_GREEN cycle 1 -> A green 5 cycles, yellow 4, all-red 2, then light_b=10 for 20 cycles, then B yellow 4.
REQ-042 SHALL cover: in B_GREEN, s drops at timer=7 -> light_b=01 on the next edge; s drops at timer=2 -> B green lasts exactly 5 cycles.
REQ-043 SHALL cover: TRAFFIC_PED_EN defined, 1-cycle ped_req during A_GREEN with s=0 -> A yellow, all-red, walk=1 for 10 cycles, back to light_a=10 with ped_pend cleared.
REQ-044 SHALL cover: rst=1 asserted at B_GREEN timer=3 -> all outputs red/0 on the next edge and the REQ-034 sequence follows.
